// File: rtl/tl_pkg.sv
// Shared TileLink-UL types for the RAM responder: A/D opcodes, the D response record
// and the address/source widths used throughout the block.
package tl_pkg;

    localparam int ADDR_W   = 14;
    localparam int SOURCE_W = 7;

    typedef enum logic [2:0] {
        PUT_FULL    = 3'd0,
        PUT_PARTIAL = 3'd1,
        ARITH       = 3'd2,
        LOGIC       = 3'd3,
        GET         = 3'd4,
        HINT        = 3'd5
    } a_opcode_e;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1,
        HINT_ACK        = 3'd2
    } d_opcode_e;

    typedef struct packed {
        d_opcode_e             opcode;
        logic [3:0]            size;
        logic [SOURCE_W-1:0]   source;
        logic                  denied;
        logic [63:0]           data;
        logic                  corrupt;
    } d_resp_t;

    // Sizes above 3 are rejected separately, so only 1/2/4/8-byte alignment matters here.
    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr, input logic [3:0] size);
        logic r;
        case (size)
            4'd1:    r = addr[0];
            4'd2:    r = |addr[1:0];
            4'd3:    r = |addr[2:0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tl_ram_responder_if.sv
// A- and D-channel bundle between a TileLink-UL master and the RAM responder.
interface tl_ram_responder_if;
    import tl_pkg::*;

    logic                io_a_valid;
    logic                io_a_ready;
    logic [2:0]          io_a_bits_opcode;
    logic [2:0]          io_a_bits_param;
    logic [3:0]          io_a_bits_size;
    logic [SOURCE_W-1:0] io_a_bits_source;
    logic [ADDR_W-1:0]   io_a_bits_address;
    logic [7:0]          io_a_bits_mask;
    logic [63:0]         io_a_bits_data;
    logic                io_a_bits_corrupt;

    logic                io_d_valid;
    logic                io_d_ready;
    logic [2:0]          io_d_bits_opcode;
    logic [1:0]          io_d_bits_param;
    logic [3:0]          io_d_bits_size;
    logic [SOURCE_W-1:0] io_d_bits_source;
    logic                io_d_bits_denied;
    logic [63:0]         io_d_bits_data;
    logic                io_d_bits_corrupt;

    modport slave (
        input  io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
               io_a_bits_source, io_a_bits_address, io_a_bits_mask, io_a_bits_data,
               io_a_bits_corrupt, io_d_ready,
        output io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
               io_d_bits_source, io_d_bits_denied, io_d_bits_data, io_d_bits_corrupt
    );

    modport master (
        output io_a_valid, io_a_bits_opcode, io_a_bits_param, io_a_bits_size,
               io_a_bits_source, io_a_bits_address, io_a_bits_mask, io_a_bits_data,
               io_a_bits_corrupt, io_d_ready,
        input  io_a_ready, io_d_valid, io_d_bits_opcode, io_d_bits_param, io_d_bits_size,
               io_d_bits_source, io_d_bits_denied, io_d_bits_data, io_d_bits_corrupt
    );

endinterface

// File: rtl/tl_resp_fifo.sv
// In-order response FIFO; the head entry is read straight from storage registers so
// the D bits stay constant while the consumer stalls.
module tl_resp_fifo
    import tl_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_enq_valid,
    input  d_resp_t                      i_enq_data,
    output logic                         o_deq_valid,
    output d_resp_t                      o_deq_data,
    input  logic                         i_deq_ready,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    d_resp_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_enq;
    logic               w_deq;

    assign w_deq       = (r_count != '0) && i_deq_ready;
    assign w_enq       = i_enq_valid && ((r_count != FULL) || w_deq);
    assign o_deq_valid = (r_count != '0);
    assign o_deq_data  = r_mem[r_rd_ptr];
    assign o_count     = r_count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: state updates use <= so every register samples pre-edge values regardless of statement order.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= i_enq_data;
                r_wr_ptr        <= (r_wr_ptr == LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tl_ram_responder.sv
// TileLink-UL memory-side responder: decodes A requests, accesses a byte-masked 64-bit
// SRAM, and returns D responses through a small FIFO (request-to-response latency 2).
module tl_ram_responder
    import tl_pkg::*;
#(
    parameter int RESP_DEPTH = 3
) (
    input  logic               clock,
    input  logic               reset,
    tl_ram_responder_if.slave  bus
);

    localparam int WORDS = 1 << (ADDR_W - 3);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    logic [63:0]        r_sram [WORDS];
    logic [63:0]        r_rd_data;
    logic               r_pipe_valid;
    d_resp_t            r_pipe_resp;

    logic [CNT_W-1:0]   w_fifo_count;
    logic [CNT_W:0]     w_occ;
    logic               w_a_fire;
    logic               w_is_put;
    logic               w_is_get;
    logic               w_denied;
    logic               w_do_write;
    logic [ADDR_W-4:0]  w_word_idx;
    d_resp_t            w_a_resp;
    d_resp_t            w_pipe_resp;
    d_resp_t            w_d_resp;
    logic               w_d_valid;
    logic               w_unused_param;

    // Ready depends only on registered occupancy, so it never waits on io_d_ready.
    assign w_occ          = {1'b0, w_fifo_count} + (CNT_W + 1)'(r_pipe_valid);
    assign bus.io_a_ready = (w_occ < (CNT_W + 1)'(RESP_DEPTH));
    assign w_a_fire       = bus.io_a_valid && bus.io_a_ready;
    assign w_word_idx     = bus.io_a_bits_address[ADDR_W-1:3];
    assign w_do_write     = w_a_fire && w_is_put && !w_denied;
    assign w_unused_param = ^bus.io_a_bits_param;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves a latch behind.
        w_a_resp = '0;
        w_is_put = 1'b0;
        w_is_get = 1'b0;
        case (bus.io_a_bits_opcode)
            PUT_FULL, PUT_PARTIAL: begin
                w_is_put        = 1'b1;
                w_a_resp.opcode = ACCESS_ACK;
            end
            GET: begin
                w_is_get        = 1'b1;
                w_a_resp.opcode = ACCESS_ACK_DATA;
            end
            ARITH, LOGIC: w_a_resp.opcode = ACCESS_ACK_DATA;
            default:      w_a_resp.opcode = ACCESS_ACK;
        endcase
        w_denied = (bus.io_a_bits_size > 4'd3)
                || is_misaligned(bus.io_a_bits_address, bus.io_a_bits_size)
                || !(w_is_put || w_is_get)
                || (w_is_put && bus.io_a_bits_corrupt);
        w_a_resp.size    = bus.io_a_bits_size;
        w_a_resp.source  = bus.io_a_bits_source;
        w_a_resp.denied  = w_denied;
        w_a_resp.corrupt = w_denied && (w_a_resp.opcode == ACCESS_ACK_DATA);
    end

    // NOTE: the SRAM array and its read register carry no reset; clearing them would block RAM inference.
    always_ff @(posedge clock) begin
        if (w_a_fire) begin
            r_rd_data <= r_sram[w_word_idx];
        end
        if (w_do_write) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.io_a_bits_mask[i]) r_sram[w_word_idx][8*i +: 8] <= bus.io_a_bits_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pipe_valid <= 1'b0;
            r_pipe_resp  <= '0;
        end else begin
            r_pipe_valid <= w_a_fire;
            if (w_a_fire) r_pipe_resp <= w_a_resp;
        end
    end

    // Only successful reads carry SRAM data; acks and denied reads return zero.
    always_comb begin
        w_pipe_resp = r_pipe_resp;
        if ((r_pipe_resp.opcode == ACCESS_ACK_DATA) && !r_pipe_resp.denied) w_pipe_resp.data = r_rd_data;
    end

    tl_resp_fifo #(.DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_enq_valid (r_pipe_valid),
        .i_enq_data  (w_pipe_resp),
        .o_deq_valid (w_d_valid),
        .o_deq_data  (w_d_resp),
        .i_deq_ready (bus.io_d_ready),
        .o_count     (w_fifo_count)
    );

    assign bus.io_d_valid        = w_d_valid;
    assign bus.io_d_bits_opcode  = w_d_resp.opcode;
    assign bus.io_d_bits_param   = 2'b00;
    assign bus.io_d_bits_size    = w_d_resp.size;
    assign bus.io_d_bits_source  = w_d_resp.source;
    assign bus.io_d_bits_denied  = w_d_resp.denied;
    assign bus.io_d_bits_data    = w_d_resp.data;
    assign bus.io_d_bits_corrupt = w_d_resp.corrupt;

endmodule
